mux4_way16: RTL and testbench

//   4-way, 16-bit-wide word multiplexer for the Hack-style datapath.
//   - Combinational output o forwards one of four data words, chosen by a 2-bit select.
//   - Registered copy o_q gives consumers a timing-clean, one-cycle-delayed version.
//   - Used wherever ALU/register/memory words are steered by a 2-bit control field.
//

---
 rtl/hack_pkg.sv | 14 +
 rtl/mux2_way16.sv | 21 ++
 rtl/mux4_way16.sv | 41 ++++
 tb/tb_mux4_way16.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared datapath types for the Hack-style word path.
// Holds the word width, word type and 2-bit select encodings.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux2_way16.sv
// 2:1 word multiplexer, purely combinational (zero latency, no backpressure).
// An unknown select drives all-X rather than favouring either input.
module mux2_way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (s)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4_way16.sv
// 4:1 word multiplexer: combinational o (zero latency) plus registered o_q (1 cycle).
// No enable or handshake; o_q reloads every edge and clears asynchronously on reset.
module mux4_way16
  import hack_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_q;

  // sel[0] picks within each pair, sel[1] picks the pair
  mux2_way16 #(.WIDTH(WIDTH)) u_mux_lo (.a(i0),   .b(i1),   .s(sel[0]), .y(w_lo));
  mux2_way16 #(.WIDTH(WIDTH)) u_mux_hi (.a(i2),   .b(i3),   .s(sel[0]), .y(w_hi));
  mux2_way16 #(.WIDTH(WIDTH)) u_mux_out(.a(w_lo), .b(w_hi), .s(sel[1]), .y(w_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_sel;
    end
  end

  assign o   = w_sel;
  assign o_q = r_q;

endmodule

// File: tb/tb_mux4_way16.sv
// Scoreboard bench for mux4_way16: directed cases then random traffic.
// The driver queues the expected o_q per clock edge; a monitor pops and compares.
module tb_mux4_way16;
  import hack_pkg::*;

  logic        clk;
  logic        rst_n;
  word_t       i0, i1, i2, i3;
  logic [1:0]  sel;
  word_t       o, o_q;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  mux4_way16 #(.WIDTH(WORD_W), .RESET_VAL(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .sel   (sel),
    .o     (o),
    .o_q   (o_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the select value is simply an index into the four data words.
  function automatic word_t ref_mux(input logic [1:0] s, input word_t a, input word_t b,
                                    input word_t c, input word_t d);
    word_t words[4];
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    return words[s];
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check o, queue expected o_q.
  task automatic drive(input logic [1:0] s, input word_t a, input word_t b,
                       input word_t c, input word_t d);
    word_t e;
    @(negedge clk);
    sel = s; i0 = a; i1 = b; i2 = c; i3 = d;
    e = ref_mux(s, a, b, c, d);
    #1 check("o_comb", o, e);
    exp_q.push_back(e);
  endtask

  // Monitor: o_q is compared one time unit after every rising edge that has an entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("o_q_reg", o_q, exp_q.pop_front());
    end
  end

  initial begin
    word_t a, b, c, d;
    logic [1:0] s;

    rst_n = 1'b0;
    sel = SEL_I0;
    i0 = 16'h1000; i1 = 16'h2000; i2 = 16'h4000; i3 = 16'h8000;
    #1;
    check("reset_o_q", o_q, 16'h0000);
    check("reset_o_live", o, 16'h1000);

    // Combinational selection with no clock involvement
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1 check("o_sel", o, ref_mux(2'(k), 16'h1000, 16'h2000, 16'h4000, 16'h8000));
    end
    sel = SEL_I2;
    #1 check("o_sel10", o, 16'h4000);
    i2 = 16'hFFFF;
    #1 check("o_follow_data", o, 16'hFFFF);
    i2 = 16'h4000;

    // Held in reset across an edge
    @(posedge clk);
    #1 check("reset_hold", o_q, 16'h0000);

    // Release reset; the first rising edge loads the word for sel=01
    @(negedge clk);
    sel = SEL_I1;
    #1 check("o_during_reset", o, 16'h2000);
    rst_n = 1'b1;
    exp_q.push_back(16'h2000);

    // o_q lags o by one cycle
    drive(SEL_I0, 16'h1000, 16'h2000, 16'h4000, 16'h8000);
    drive(SEL_I1, 16'h1000, 16'h2000, 16'h4000, 16'h8000);
    drive(SEL_I2, 16'h1000, 16'h2000, 16'h4000, 16'h8000);
    drive(SEL_I3, 16'h1000, 16'h2000, 16'h4000, 16'h8000);

    // Async reset between edges clears o_q without a clock
    @(posedge clk);
    #2;
    check("pre_async", o_q, 16'h8000);
    rst_n = 1'b0;
    #1;
    check("async_clear", o_q, 16'h0000);
    check("o_unaffected", o, 16'h8000);
    @(negedge clk);
    rst_n = 1'b1;

    // Lane-crossing patterns
    for (int k = 0; k < 4; k++)
      drive(2'(k), 16'hAAAA, 16'h5555, 16'h0000, 16'hFFFF);

    // Random traffic: sel and data change together each cycle
    for (int n = 0; n < 200; n++) begin
      s = 2'($urandom_range(0, 3));
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      drive(s, a, b, c, d);
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
